// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle controller: FSM state encoding,
// RV32I base opcodes and the encodings of the datapath control fields.
package mc_control_pkg;

  // FSM states
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // Plain constants of the same values for legacy-style state registers
  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] TRAP   = 3'd5;

  // Supported opcodes (inst[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Next-PC source
  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_PCIMM  = 2'b01;
  localparam logic [1:0] NPC_RS1IMM = 2'b10;

  // Immediate format
  localparam logic [2:0] SEXT_I = 3'd0;
  localparam logic [2:0] SEXT_S = 3'd1;
  localparam logic [2:0] SEXT_B = 3'd2;
  localparam logic [2:0] SEXT_J = 3'd3;
  localparam logic [2:0] SEXT_U = 3'd4;

  // Register-file write-data source
  localparam logic [2:0] WD_ALU   = 3'b000;
  localparam logic [2:0] WD_PC4   = 3'b001;
  localparam logic [2:0] WD_LOAD  = 3'b010;
  localparam logic [2:0] WD_IMM   = 3'b011;
  localparam logic [2:0] WD_PCIMM = 3'b100;

  // ALU operations; branches use SUB for equality, SLT/SLTU for ordering
  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_SLL  = 6'd2;
  localparam logic [5:0] ALU_SLT  = 6'd3;
  localparam logic [5:0] ALU_SLTU = 6'd4;
  localparam logic [5:0] ALU_XOR  = 6'd5;
  localparam logic [5:0] ALU_SRL  = 6'd6;
  localparam logic [5:0] ALU_SRA  = 6'd7;
  localparam logic [5:0] ALU_OR   = 6'd8;
  localparam logic [5:0] ALU_AND  = 6'd9;

  // Branch condition from funct3 and the ALU compare flags. The unsigned
  // variants reuse lt because the ALU was told to do an unsigned compare.
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic       lt,
                                        input logic       eq);
    logic taken;
    case (funct3)
      3'b000:  taken = eq;
      3'b001:  taken = ~eq;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = lt;
      3'b111:  taken = ~lt;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mc_control_decode.sv
// Combinational instruction decode: maps opcode, funct3 and inst[30] onto
// the datapath control fields plus a few class flags used by the FSM.
module mc_decode
  import mc_control_pkg::*;
(
  input  logic [31:0] inst,
  output logic [1:0]  npc_op,
  output logic [2:0]  sext_op,
  output logic [2:0]  wd_sel,
  output logic        alub_sel,
  output logic [5:0]  alu_op,
  output logic [1:0]  mask_op,
  output logic        sign,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign alt    = inst[30];

  // Arithmetic/logic op from funct3; alt_en selects SUB/SRA variants
  function automatic logic [5:0] arith_op(input logic [2:0] f3,
                                          input logic       alt_en);
    logic [5:0] op;
    case (f3)
      3'b000:  op = alt_en ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt_en ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Per-opcode field selection; unknown opcodes flag illegal
  always_comb begin
    npc_op    = NPC_PC4;
    sext_op   = SEXT_I;
    wd_sel    = WD_ALU;
    alub_sel  = 1'b0;
    alu_op    = ALU_ADD;
    mask_op   = funct3[1:0];
    sign      = ~((funct3 == 3'b100) || (funct3 == 3'b101));
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    legal     = 1'b1;
    case (opcode)
      OP_R: begin
        alu_op = arith_op(funct3, alt);
      end
      OP_IMM: begin
        // inst[30] is immediate data for addi, only meaningful for shifts
        alub_sel = 1'b1;
        alu_op   = arith_op(funct3, alt && (funct3 == 3'b101));
      end
      OP_LOAD: begin
        alub_sel = 1'b1;
        wd_sel   = WD_LOAD;
        is_load  = 1'b1;
      end
      OP_STORE: begin
        sext_op  = SEXT_S;
        alub_sel = 1'b1;
        is_store = 1'b1;
      end
      OP_BRANCH: begin
        sext_op   = SEXT_B;
        is_branch = 1'b1;
        if (funct3[2:1] == 2'b11)
          alu_op = ALU_SLTU;
        else if (funct3[2])
          alu_op = ALU_SLT;
        else
          alu_op = ALU_SUB;
      end
      OP_JAL: begin
        npc_op  = NPC_PCIMM;
        sext_op = SEXT_J;
        wd_sel  = WD_PC4;
      end
      OP_JALR: begin
        npc_op  = NPC_RS1IMM;
        sext_op = SEXT_I;
        wd_sel  = WD_PC4;
      end
      OP_LUI: begin
        sext_op = SEXT_U;
        wd_sel  = WD_IMM;
      end
      OP_AUIPC: begin
        sext_op = SEXT_U;
        wd_sel  = WD_PCIMM;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle processor controller: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory handshakes with an ack timeout, sticky trap and retired count.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      inst_i,
  input  logic             lt_i,
  input  logic             eq_i,
  output logic             imem_req_o,
  input  logic             imem_ack_i,
  output logic             dmem_req_o,
  input  logic             dmem_ack_i,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             rf_we_o,
  output logic             dram_we_o,
  output logic [1:0]       npc_op_o,
  output logic [2:0]       sext_op_o,
  output logic [2:0]       wd_sel_o,
  output logic             alub_sel_o,
  output logic [5:0]       alu_op_o,
  output logic [1:0]       mask_op_o,
  output logic             sign_o,
  output logic [2:0]       state_o,
  output logic             trap_o,
  output logic [CNT_W-1:0] instret_o
);

  // Wait counter only has to hold 0..TIMEOUT-1
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_expired;
  logic [CNT_W-1:0]  instret;

  logic [1:0] npc_op;
  logic [2:0] sext_op;
  logic [2:0] wd_sel;
  logic       alub_sel;
  logic [5:0] alu_op;
  logic [1:0] mask_op;
  logic       sign;
  logic       is_load;
  logic       is_store;
  logic       is_branch;
  logic [2:0] br_f3;

  logic [1:0] dec_npc_op;
  logic [2:0] dec_sext_op;
  logic [2:0] dec_wd_sel;
  logic       dec_alub_sel;
  logic [5:0] dec_alu_op;
  logic [1:0] dec_mask_op;
  logic       dec_sign;
  logic       dec_is_load;
  logic       dec_is_store;
  logic       dec_is_branch;
  logic       dec_legal;

  mc_decode u_decode (
    .inst      (inst_i),
    .npc_op    (dec_npc_op),
    .sext_op   (dec_sext_op),
    .wd_sel    (dec_wd_sel),
    .alub_sel  (dec_alub_sel),
    .alu_op    (dec_alu_op),
    .mask_op   (dec_mask_op),
    .sign      (dec_sign),
    .is_load   (dec_is_load),
    .is_store  (dec_is_store),
    .is_branch (dec_is_branch),
    .legal     (dec_legal)
  );

  assign wait_expired = (wait_cnt == WAIT_LAST);

  // Next-state selection; an ack in the last allowed wait cycle still wins
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (imem_ack_i)
          state_nxt = DECODE;
        else if (wait_expired)
          state_nxt = TRAP;
      end
      DECODE: state_nxt = dec_legal ? EXEC : TRAP;
      EXEC:   state_nxt = (is_load || is_store) ? MEM : WB;
      MEM: begin
        if (dmem_ack_i)
          state_nxt = WB;
        else if (wait_expired)
          state_nxt = TRAP;
      end
      WB:      state_nxt = FETCH;
      TRAP:    state_nxt = TRAP;
      default: state_nxt = TRAP;
    endcase
  end

  // State register and handshake wait counter (cleared on any state change)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if ((state == FETCH) || (state == MEM))
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Control fields captured in DECODE; branch target choice resolved in EXEC
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      npc_op    <= '0;
      sext_op   <= '0;
      wd_sel    <= '0;
      alub_sel  <= 1'b0;
      alu_op    <= '0;
      mask_op   <= '0;
      sign      <= 1'b0;
      is_load   <= 1'b0;
      is_store  <= 1'b0;
      is_branch <= 1'b0;
      br_f3     <= '0;
    end else if (state == DECODE) begin
      npc_op    <= dec_npc_op;
      sext_op   <= dec_sext_op;
      wd_sel    <= dec_wd_sel;
      alub_sel  <= dec_alub_sel;
      alu_op    <= dec_alu_op;
      mask_op   <= dec_mask_op;
      sign      <= dec_sign;
      is_load   <= dec_is_load;
      is_store  <= dec_is_store;
      is_branch <= dec_is_branch;
      br_f3     <= inst_i[14:12];
    end else if ((state == EXEC) && is_branch) begin
      npc_op <= branch_taken(br_f3, lt_i, eq_i) ? NPC_PCIMM : NPC_PC4;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk_i) begin
    if (rst_i)
      instret <= '0;
    else if (state == WB)
      instret <= instret + CNT_W'(1);
  end

  // Strobes and requests decode from state; held low while reset is applied
  assign imem_req_o = ~rst_i && (state == FETCH);
  assign ir_we_o    = ~rst_i && (state == FETCH) && imem_ack_i;
  assign dmem_req_o = ~rst_i && (state == MEM);
  assign dram_we_o  = ~rst_i && (state == MEM) && is_store;
  assign pc_we_o    = ~rst_i && (state == WB);
  assign rf_we_o    = ~rst_i && (state == WB) && ~(is_store || is_branch);

  assign npc_op_o   = npc_op;
  assign sext_op_o  = sext_op;
  assign wd_sel_o   = wd_sel;
  assign alub_sel_o = alub_sel;
  assign alu_op_o   = alu_op;
  assign mask_op_o  = mask_op;
  assign sign_o     = sign;
  assign state_o    = state;
  assign trap_o     = (state == TRAP);
  assign instret_o  = instret;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: a default-parameter instance plus a
// TIMEOUT=4 / CNT_W=4 instance sharing the same inputs.
module tb_mc_control;
  import mc_control_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, lt, eq, imem_ack, dmem_ack;
  logic [31:0] inst;

  logic        imem_req, dmem_req, ir_we, pc_we, rf_we, dram_we, alub_sel, sign, trap;
  logic [1:0]  npc_op, mask_op;
  logic [2:0]  sext_op, wd_sel, state;
  logic [5:0]  alu_op;
  logic [31:0] instret;

  logic        imem_req_b, dmem_req_b, ir_we_b, pc_we_b, rf_we_b, dram_we_b, alub_sel_b, sign_b, trap_b;
  logic [1:0]  npc_op_b, mask_op_b;
  logic [2:0]  sext_op_b, wd_sel_b, state_b;
  logic [5:0]  alu_op_b;
  logic [3:0]  instret_b;

  int checks = 0;
  int failures = 0;

  mc_control dut (
    .clk_i(clk), .rst_i(rst), .inst_i(inst), .lt_i(lt), .eq_i(eq),
    .imem_req_o(imem_req), .imem_ack_i(imem_ack), .dmem_req_o(dmem_req), .dmem_ack_i(dmem_ack),
    .ir_we_o(ir_we), .pc_we_o(pc_we), .rf_we_o(rf_we), .dram_we_o(dram_we),
    .npc_op_o(npc_op), .sext_op_o(sext_op), .wd_sel_o(wd_sel), .alub_sel_o(alub_sel),
    .alu_op_o(alu_op), .mask_op_o(mask_op), .sign_o(sign),
    .state_o(state), .trap_o(trap), .instret_o(instret)
  );

  mc_control #(.TIMEOUT(4), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .inst_i(inst), .lt_i(lt), .eq_i(eq),
    .imem_req_o(imem_req_b), .imem_ack_i(imem_ack), .dmem_req_o(dmem_req_b), .dmem_ack_i(dmem_ack),
    .ir_we_o(ir_we_b), .pc_we_o(pc_we_b), .rf_we_o(rf_we_b), .dram_we_o(dram_we_b),
    .npc_op_o(npc_op_b), .sext_op_o(sext_op_b), .wd_sel_o(wd_sel_b), .alub_sel_o(alub_sel_b),
    .alu_op_o(alu_op_b), .mask_op_o(mask_op_b), .sign_o(sign_b),
    .state_o(state_b), .trap_o(trap_b), .instret_o(instret_b)
  );

  // Present an instruction with an immediate fetch ack; returns in EXEC
  task automatic issue(input logic [31:0] ins);
    inst = ins; imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic apply_reset();
    imem_ack = 1'b0; dmem_ack = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; inst = '0; lt = 1'b0; eq = 1'b0;
    repeat (3) @(negedge clk); #1;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_imem_req got=%b exp=0", imem_req); end
    checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL rst_dmem_req got=%b exp=0", dmem_req); end
    checks++; if (trap !== 1'b0) begin failures++; $display("FAIL rst_trap got=%b exp=0", trap); end
    checks++; if (instret !== 32'd0) begin failures++; $display("FAIL rst_instret got=%0d exp=0", instret); end
    checks++; if ({npc_op, sext_op, wd_sel, alub_sel, alu_op, mask_op, sign} !== 18'd0) begin
      failures++; $display("FAIL rst_ctrl got=%h exp=0", {npc_op, sext_op, wd_sel, alub_sel, alu_op, mask_op, sign}); end
    rst = 1'b0; #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_imem_req got=%b exp=1", imem_req); end
  endtask

  task automatic test_addi();
    inst = 32'h00500093; imem_ack = 1'b1; #1;
    checks++; if (ir_we !== 1'b1) begin failures++; $display("FAIL addi_ir_we got=%b exp=1", ir_we); end
    @(negedge clk); imem_ack = 1'b0; #1;
    checks++; if (state !== 3'd1 || ir_we !== 1'b0) begin failures++; $display("FAIL addi_decode state=%0d ir_we=%b exp 1/0", state, ir_we); end
    @(negedge clk); #1;
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL addi_exec got=%0d exp=2", state); end
    checks++; if (sext_op !== 3'd0 || alub_sel !== 1'b1 || wd_sel !== 3'd0 || sign !== 1'b1) begin
      failures++; $display("FAIL addi_fields sext=%0d alub=%b wd=%0d sign=%b exp 0/1/0/1", sext_op, alub_sel, wd_sel, sign); end
    checks++; if (alu_op !== ALU_ADD) begin failures++; $display("FAIL addi_alu got=%0d exp=%0d", alu_op, ALU_ADD); end
    @(negedge clk); #1;
    checks++; if (state !== 3'd4 || rf_we !== 1'b1 || pc_we !== 1'b1 || instret !== 32'd0) begin
      failures++; $display("FAIL addi_wb state=%0d rf=%b pc=%b instret=%0d exp 4/1/1/0", state, rf_we, pc_we, instret); end
    @(negedge clk); #1;
    checks++; if (state !== 3'd0 || instret !== 32'd1 || instret_b !== 4'd1) begin
      failures++; $display("FAIL addi_retire state=%0d instret=%0d instret_b=%0d exp 0/1/1", state, instret, instret_b); end
  endtask

  task automatic test_branch();
    logic [31:0] ins_t [4] = '{32'h00000063, 32'h00000063, 32'h00006063, 32'h00005063};
    logic        lt_t  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        eq_t  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  npc_t [4] = '{2'b01, 2'b00, 2'b01, 2'b00};
    logic [5:0]  alu_t [4] = '{ALU_SUB, ALU_SUB, ALU_SLTU, ALU_SLT};
    for (int i = 0; i < 4; i++) begin
      issue(ins_t[i]);
      lt = lt_t[i]; eq = eq_t[i]; #1;
      checks++; if (state !== 3'd2 || sext_op !== 3'd2 || alu_op !== alu_t[i]) begin
        failures++; $display("FAIL br%0d_exec state=%0d sext=%0d alu=%0d exp 2/2/%0d", i, state, sext_op, alu_op, alu_t[i]); end
      @(negedge clk); #1;
      checks++; if (state !== 3'd4 || npc_op !== npc_t[i] || rf_we !== 1'b0 || pc_we !== 1'b1) begin
        failures++; $display("FAIL br%0d_wb state=%0d npc=%b rf=%b pc=%b exp 4/%b/0/1", i, state, npc_op, rf_we, pc_we, npc_t[i]); end
      lt = 1'b0; eq = 1'b0;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_store();
    int hi = 0;
    issue(32'h00112023);
    checks++; if (sext_op !== 3'd1 || alub_sel !== 1'b1 || mask_op !== 2'd2 || sign !== 1'b1) begin
      failures++; $display("FAIL sw_fields sext=%0d alub=%b mask=%0d sign=%b exp 1/1/2/1", sext_op, alub_sel, mask_op, sign); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); dmem_ack = (k == 3); #1;
      if (dram_we === 1'b1) hi++;
      if (k == 0) begin
        checks++; if (state !== 3'd3 || dmem_req !== 1'b1) begin failures++; $display("FAIL sw_mem state=%0d req=%b exp 3/1", state, dmem_req); end
      end
      if (k == 4) begin
        checks++; if (state !== 3'd4 || rf_we !== 1'b0 || pc_we !== 1'b1 || dmem_req !== 1'b0) begin
          failures++; $display("FAIL sw_wb state=%0d rf=%b pc=%b req=%b exp 4/0/1/0", state, rf_we, pc_we, dmem_req); end
        checks++; if (state_b !== 3'd4 || trap_b !== 1'b0) begin failures++; $display("FAIL sw_wb_t4 state=%0d trap=%b exp 4/0", state_b, trap_b); end
      end
    end
    dmem_ack = 1'b0;
    checks++; if (hi != 4) begin failures++; $display("FAIL sw_dram_we_cycles got=%0d exp=4", hi); end
  endtask

  task automatic test_load();
    issue(32'h0000C083);
    checks++; if (wd_sel !== 3'd2 || sign !== 1'b0 || mask_op !== 2'd0 || alub_sel !== 1'b1) begin
      failures++; $display("FAIL lbu_fields wd=%0d sign=%b mask=%0d alub=%b exp 2/0/0/1", wd_sel, sign, mask_op, alub_sel); end
    @(negedge clk); dmem_ack = 1'b1; #1;
    checks++; if (state !== 3'd3 || dmem_req !== 1'b1 || dram_we !== 1'b0) begin
      failures++; $display("FAIL lbu_mem state=%0d req=%b dram_we=%b exp 3/1/0", state, dmem_req, dram_we); end
    @(negedge clk); dmem_ack = 1'b0; #1;
    checks++; if (state !== 3'd4 || rf_we !== 1'b1) begin failures++; $display("FAIL lbu_wb state=%0d rf=%b exp 4/1", state, rf_we); end
    @(negedge clk); #1;
  endtask

  task automatic test_jump_upper();
    logic [31:0] ins_t  [3] = '{32'h000000EF, 32'h000080E7, 32'h000010B7};
    logic [1:0]  npc_t  [3] = '{2'b01, 2'b10, 2'b00};
    logic [2:0]  sext_t [3] = '{3'd3, 3'd0, 3'd4};
    logic [2:0]  wd_t   [3] = '{3'd1, 3'd1, 3'd3};
    for (int i = 0; i < 3; i++) begin
      issue(ins_t[i]);
      checks++; if (npc_op !== npc_t[i] || sext_op !== sext_t[i] || wd_sel !== wd_t[i] || alub_sel !== 1'b0) begin
        failures++; $display("FAIL jmp%0d_fields npc=%b sext=%0d wd=%0d alub=%b exp %b/%0d/%0d/0", i, npc_op, sext_op, wd_sel, alub_sel, npc_t[i], sext_t[i], wd_t[i]); end
      @(negedge clk); #1;
      checks++; if (state !== 3'd4 || rf_we !== 1'b1) begin failures++; $display("FAIL jmp%0d_wb state=%0d rf=%b exp 4/1", i, state, rf_we); end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    int act = 0;
    issue(32'h0000007F);
    checks++; if (state !== 3'd5 || trap !== 1'b1 || imem_req !== 1'b0) begin
      failures++; $display("FAIL ill_trap state=%0d trap=%b req=%b exp 5/1/0", state, trap, imem_req); end
    imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      if (pc_we || ir_we || rf_we || dram_we || imem_req || dmem_req) act++;
    end
    checks++; if (act != 0 || state !== 3'd5) begin failures++; $display("FAIL ill_quiet active=%0d state=%0d exp 0/5", act, state); end
    apply_reset();
    checks++; if (state !== 3'd0 || trap !== 1'b0 || trap_b !== 1'b0) begin
      failures++; $display("FAIL ill_reset state=%0d trap=%b trap_b=%b exp 0/0/0", state, trap, trap_b); end
  endtask

  task automatic test_timeout();
    apply_reset();
    repeat (3) @(negedge clk); #1;
    checks++; if (state_b !== 3'd0 || imem_req_b !== 1'b1) begin failures++; $display("FAIL to_wait state=%0d req=%b exp 0/1", state_b, imem_req_b); end
    @(negedge clk); #1;
    checks++; if (state_b !== 3'd5 || trap_b !== 1'b1 || imem_req_b !== 1'b0) begin
      failures++; $display("FAIL to_trap state=%0d trap=%b req=%b exp 5/1/0", state_b, trap_b, imem_req_b); end
    checks++; if (state !== 3'd0 || imem_req !== 1'b1) begin failures++; $display("FAIL to_long state=%0d req=%b exp 0/1", state, imem_req); end
    apply_reset();
  endtask

  task automatic test_reset_mem();
    issue(32'h00112023);
    @(negedge clk); #1;
    checks++; if (state !== 3'd3 || dmem_req !== 1'b1) begin failures++; $display("FAIL rm_mem state=%0d req=%b exp 3/1", state, dmem_req); end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (state !== 3'd0 || dmem_req !== 1'b0 || dram_we !== 1'b0 || state_b !== 3'd0) begin
      failures++; $display("FAIL rm_abort state=%0d req=%b we=%b state_b=%0d exp 0/0/0/0", state, dmem_req, dram_we, state_b); end
    rst = 1'b0; #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rm_refetch got=%b exp=1", imem_req); end
  endtask

  task automatic test_back_to_back();
    time t0;
    apply_reset();
    t0 = $time;
    for (int i = 0; i < 17; i++) begin
      issue(32'h00500093);
      @(negedge clk); @(negedge clk); #1;
      if (i == 15) begin
        checks++; if (instret_b !== 4'd0) begin failures++; $display("FAIL wrap16 got=%0d exp=0", instret_b); end
      end
    end
    checks++; if (instret_b !== 4'd1) begin failures++; $display("FAIL wrap17 got=%0d exp=1", instret_b); end
    checks++; if (instret !== 32'd17) begin failures++; $display("FAIL instret17 got=%0d exp=17", instret); end
    checks++; if (($time - t0) != 680) begin failures++; $display("FAIL throughput got=%0t exp=680", $time - t0); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_store();
    test_load();
    test_jump_upper();
    test_illegal();
    test_timeout();
    test_reset_mem();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
